// File: rtl/riscv_regfile_bist_ctrl.sv
// March C- MBIST controller driving the integer register-file 1RW test port.
// Sequences the six march elements, compares read data one cycle later and keeps pass/fail status.
module riscv_regfile_bist_ctrl #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  BIST_o,
  output logic                  CSN_T_o,
  output logic                  WEN_T_o,
  output logic [ADDR_WIDTH-1:0] A_T_o,
  output logic [DATA_WIDTH-1:0] D_T_o,
  input  logic [DATA_WIDTH-1:0] Q_T_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [7:0]            err_cnt_o
);

  localparam int IW = ADDR_WIDTH - 1;
  // Highest all-ones index is skipped: the wrapper inverts it onto x0.
  localparam logic [IW-1:0] LAST_IDX = {{(IW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start_run;

  logic [2:0]    r_elem;
  logic [IW-1:0] r_addr;
  logic          r_phase;

  logic                  r_exp_vld_p1;
  logic [DATA_WIDTH-1:0] r_exp_data_p1;
  logic [ADDR_WIDTH-1:0] r_exp_addr_p1;
  logic [2:0]            r_exp_elem_p1;

  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;
  logic [7:0]            r_err_cnt;

  logic                  w_is_rw;
  logic                  w_up;
  logic                  w_read;
  logic                  w_elem_end;
  logic                  w_mis;
  logic [IW-1:0]         w_end_idx;
  logic [IW-1:0]         w_next_start;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Element decode: M1..M4 are r,w pairs; M3/M4 walk downwards.
  assign w_is_rw      = (r_elem >= 3'd1) && (r_elem <= 3'd4);
  assign w_up         = (r_elem != 3'd3) && (r_elem != 3'd4);
  assign w_read       = w_is_rw ? ~r_phase : (r_elem == 3'd5);
  assign w_end_idx    = w_up ? LAST_IDX : '0;
  assign w_elem_end   = (r_addr == w_end_idx) && (!w_is_rw || r_phase);
  assign w_next_start = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? LAST_IDX : '0;
  assign w_wdata      = r_elem[0] ? ~BG_PATTERN : BG_PATTERN;
  assign w_rdata      = r_elem[0] ? BG_PATTERN : ~BG_PATTERN;
  assign w_mis        = r_exp_vld_p1 && (Q_T_i != r_exp_data_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    BIST_o      = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    CSN_T_o     = 1'b1;
    WEN_T_o     = 1'b1;
    A_T_o       = '0;
    D_T_o       = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
        end
      end
      S_RUN: begin
        BIST_o  = 1'b1;
        busy_o  = 1'b1;
        CSN_T_o = 1'b0;
        WEN_T_o = w_read;
        A_T_o   = {1'b0, r_addr};
        D_T_o   = w_wdata;
        if ((r_elem == 3'd5) && w_elem_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        BIST_o      = 1'b1;
        busy_o      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address/element sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem  <= 3'd0;
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else if (w_start_run) begin
      r_elem  <= 3'd0;
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_is_rw && !r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        if (w_elem_end) begin
          if (r_elem != 3'd5) begin
            r_elem <= r_elem + 3'd1;
            r_addr <= w_next_start;
          end
        end else if (w_up) begin
          r_addr <= r_addr + 1'b1;
        end else begin
          r_addr <= r_addr - 1'b1;
        end
      end
    end
  end

  // p0 -> p1: read issued this cycle, expectation held for next-cycle compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_exp_vld_p1 <= 1'b0;
    else        r_exp_vld_p1 <= (r_state == S_RUN) && w_read;
  end

  always_ff @(posedge clk) begin
    r_exp_data_p1 <= w_rdata;
    r_exp_addr_p1 <= {1'b0, r_addr};
    r_exp_elem_p1 <= r_elem;
  end

  // p1: compare and status update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_err_cnt   <= 8'd0;
    end else if (w_start_run) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_err_cnt   <= 8'd0;
    end else if (w_mis) begin
      r_err_cnt <= sat_inc8(r_err_cnt);
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_exp_addr_p1;
        r_fail_elem <= r_exp_elem_p1;
      end
    end
  end

  assign fail_o      = r_fail;
  assign fail_addr_o = r_fail_addr;
  assign fail_elem_o = r_fail_elem;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_riscv_regfile_bist_ctrl.sv
// Bench for riscv_regfile_bist_ctrl: a faultable regfile model answers the test port,
// and a table-driven March C- reference predicts the op trace and the resulting status.
module tb_riscv_regfile_bist_ctrl;

  localparam int          NOPS = 150;
  localparam logic [31:0] BG   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        BIST_o, CSN_T_o, WEN_T_o;
  logic [4:0]  A_T_o;
  logic [31:0] D_T_o;
  logic [31:0] Q_T_i;
  logic        busy_o, done_o, fail_o;
  logic [4:0]  fail_addr_o;
  logic [2:0]  fail_elem_o;
  logic [7:0]  err_cnt_o;

  riscv_regfile_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .BIST_o(BIST_o), .CSN_T_o(CSN_T_o), .WEN_T_o(WEN_T_o),
    .A_T_o(A_T_o), .D_T_o(D_T_o), .Q_T_i(Q_T_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fault injection: 0 none, 1 stuck-1 bit0 @3, 2 Q forced DEADBEEF, 3 random stuck bit
  int fmode = 0;
  int f_addr = 0;
  int f_bit = 0;
  logic f_val = 1'b0;

  function automatic logic [31:0] apply_fault(input logic [31:0] v, input int a);
    logic [31:0] r;
    r = v;
    case (fmode)
      1: if (a == 3) r[0] = 1'b1;
      2: r = 32'hDEADBEEF;
      3: if (a == f_addr) r[f_bit] = f_val;
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] mem [16];
  logic [31:0] q_reg = 32'h0;
  assign Q_T_i = q_reg;

  always @(posedge clk) begin
    if (BIST_o && !CSN_T_o) begin
      if (!WEN_T_o) mem[A_T_o[3:0]] <= D_T_o;
      else          q_reg <= apply_fault(mem[A_T_o[3:0]], int'(A_T_o[3:0]));
    end
  end

  // Reference op list built from the march table
  logic        exp_wen [NOPS];
  logic [4:0]  exp_a   [NOPS];
  logic [31:0] exp_d   [NOPS];
  logic [2:0]  exp_e   [NOPS];

  task automatic build_march();
    bit          up_tbl [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit          rd_tbl [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          wr_tbl [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rv_tbl [6] = '{BG, BG, ~BG, BG, ~BG, BG};
    logic [31:0] wv_tbl [6] = '{BG, ~BG, BG, ~BG, BG, BG};
    int i = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 15; k++) begin
        int a;
        a = up_tbl[e] ? k : 14 - k;
        if (rd_tbl[e]) begin
          exp_wen[i] = 1'b1; exp_a[i] = 5'(a); exp_d[i] = rv_tbl[e]; exp_e[i] = 3'(e); i++;
        end
        if (wr_tbl[e]) begin
          exp_wen[i] = 1'b0; exp_a[i] = 5'(a); exp_d[i] = wv_tbl[e]; exp_e[i] = 3'(e); i++;
        end
      end
    end
  endtask

  // Predicts status of a run against the currently selected fault
  int         m_cnt;
  logic       m_fail;
  logic [4:0] m_faddr;
  logic [2:0] m_felem;

  task automatic model_run();
    logic [31:0] m [15];
    logic [31:0] got;
    m_cnt = 0; m_fail = 1'b0; m_faddr = 5'd0; m_felem = 3'd0;
    for (int k = 0; k < 15; k++) m[k] = 32'h0;
    for (int i = 0; i < NOPS; i++) begin
      if (!exp_wen[i]) m[exp_a[i]] = exp_d[i];
      else begin
        got = apply_fault(m[exp_a[i]], int'(exp_a[i]));
        if (got != exp_d[i]) begin
          if (m_cnt < 255) m_cnt++;
          if (!m_fail) begin m_fail = 1'b1; m_faddr = exp_a[i]; m_felem = exp_e[i]; end
        end
      end
    end
  endtask

  // Observations recorded by do_run
  int   done_at, bist_cyc, tr_bad;
  logic first_fail;
  logic [7:0] first_err;
  logic ab_bist, ab_csn, ab_busy, ab_done;

  task automatic do_run(input int pulse_at, input int abort_at, input bit hold);
    done_at = -1; bist_cyc = 0; tr_bad = 0;
    @(negedge clk); start_i = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 400 && done_at < 0; n++) begin
      @(negedge clk);
      if (!hold) start_i = (n == pulse_at);
      if (n == 1) begin first_fail = fail_o; first_err = err_cnt_o; end
      if (n == abort_at) begin
        rst_n = 1'b0; start_i = 1'b0;
        #1;
        ab_bist = BIST_o; ab_csn = CSN_T_o; ab_busy = busy_o; ab_done = done_o;
        return;
      end
      if (busy_o !== BIST_o) tr_bad++;
      if (!CSN_T_o && A_T_o[3:0] == 4'hF) tr_bad++;
      if (done_o) done_at = n;
      else if (BIST_o) begin
        if (bist_cyc < NOPS) begin
          if (CSN_T_o !== 1'b0 || WEN_T_o !== exp_wen[bist_cyc] || A_T_o !== exp_a[bist_cyc] ||
              (!exp_wen[bist_cyc] && D_T_o !== exp_d[bist_cyc])) tr_bad++;
        end else if (CSN_T_o !== 1'b1) tr_bad++;
        bist_cyc++;
      end else tr_bad++;
    end
    if (!hold) start_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (BIST_o !== 1'b0 || CSN_T_o !== 1'b1 || WEN_T_o !== 1'b1) begin
      failures++; $display("FAIL reset_port: BIST=%b CSN=%b WEN=%b required 0 1 1", BIST_o, CSN_T_o, WEN_T_o); end
    checks++; if (A_T_o !== 5'd0 || D_T_o !== 32'd0) begin
      failures++; $display("FAIL reset_addr_data: A=%h D=%h required 0 0", A_T_o, D_T_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || fail_o !== 1'b0) begin
      failures++; $display("FAIL reset_status: busy=%b done=%b fail=%b required 0 0 0", busy_o, done_o, fail_o); end
    checks++; if (err_cnt_o !== 8'd0 || fail_addr_o !== 5'd0 || fail_elem_o !== 3'd0) begin
      failures++; $display("FAIL reset_info: err=%0d addr=%h elem=%0d required 0 0 0", err_cnt_o, fail_addr_o, fail_elem_o); end
  endtask

  task automatic test_clean_run();
    fmode = 0; model_run();
    do_run(0, 0, 1'b0);
    checks++; if (done_at !== 152) begin
      failures++; $display("FAIL clean_done_latency: got %0d required 152", done_at); end
    checks++; if (bist_cyc !== 151) begin
      failures++; $display("FAIL clean_bist_cycles: got %0d required 151", bist_cyc); end
    checks++; if (tr_bad !== 0) begin
      failures++; $display("FAIL clean_trace: %0d bad cycles required 0", tr_bad); end
    checks++; if (fail_o !== m_fail || err_cnt_o !== 8'(m_cnt)) begin
      failures++; $display("FAIL clean_status: fail=%b err=%0d required %b %0d", fail_o, err_cnt_o, m_fail, m_cnt); end
    checks++; if (BIST_o !== 1'b0 || CSN_T_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b1) begin
      failures++; $display("FAIL clean_done_port: BIST=%b CSN=%b busy=%b done=%b required 0 1 0 1",
                           BIST_o, CSN_T_o, busy_o, done_o); end
  endtask

  task automatic test_fault(input int mode, input string name);
    fmode = mode; model_run();
    do_run(0, 0, 1'b0);
    checks++; if (done_at !== 152 || tr_bad !== 0) begin
      failures++; $display("FAIL %s_run: done_at=%0d trace_bad=%0d required 152 0", name, done_at, tr_bad); end
    checks++; if (fail_o !== m_fail || err_cnt_o !== 8'(m_cnt)) begin
      failures++; $display("FAIL %s_count: fail=%b err=%0d required %b %0d", name, fail_o, err_cnt_o, m_fail, m_cnt); end
    checks++; if (m_fail && (fail_addr_o !== m_faddr || fail_elem_o !== m_felem)) begin
      failures++; $display("FAIL %s_first: addr=%h elem=%0d required %h %0d", name, fail_addr_o, fail_elem_o, m_faddr, m_felem); end
  endtask

  task automatic test_stuck_bit0();
    test_fault(1, "stuck_bit0");
    checks++; if (fail_addr_o !== 5'h03 || fail_elem_o !== 3'd1 || err_cnt_o !== 8'd3) begin
      failures++; $display("FAIL stuck_bit0_abs: addr=%h elem=%0d err=%0d required 03 1 3", fail_addr_o, fail_elem_o, err_cnt_o); end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 4; r++) begin
      f_addr = $urandom_range(0, 14); f_bit = $urandom_range(0, 31); f_val = 1'($urandom_range(0, 1));
      test_fault(3, "rand_stuck");
    end
  endtask

  task automatic test_start_ignored();
    fmode = 0;
    do_run(10, 0, 1'b0);
    checks++; if (done_at !== 152 || bist_cyc !== 151 || tr_bad !== 0) begin
      failures++; $display("FAIL start_ignored: done_at=%0d bist=%0d bad=%0d required 152 151 0", done_at, bist_cyc, tr_bad); end
  endtask

  task automatic test_reset_midrun();
    fmode = 0;
    do_run(0, 40, 1'b0);
    checks++; if (ab_bist !== 1'b0 || ab_csn !== 1'b1 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin
      failures++; $display("FAIL midrun_reset: BIST=%b CSN=%b busy=%b done=%b required 0 1 0 0", ab_bist, ab_csn, ab_busy, ab_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_clean_run();
  endtask

  task automatic test_restart_after_fail();
    test_fault(2, "forced_q");
    fmode = 0; model_run();
    do_run(0, 0, 1'b0);
    checks++; if (first_fail !== 1'b0 || first_err !== 8'd0) begin
      failures++; $display("FAIL restart_clear: fail=%b err=%0d required 0 0", first_fail, first_err); end
    checks++; if (fail_o !== 1'b0 || err_cnt_o !== 8'd0 || done_at !== 152) begin
      failures++; $display("FAIL restart_pass: fail=%b err=%0d done_at=%0d required 0 0 152", fail_o, err_cnt_o, done_at); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int seen_done;
    fmode = 0;
    do_run(0, 0, 1'b1);
    @(negedge clk);
    checks++; if (done_at !== 152 || busy_o !== 1'b1 || done_o !== 1'b0 || BIST_o !== 1'b1) begin
      failures++; $display("FAIL b2b_restart: done_at=%0d busy=%b done=%b BIST=%b required 152 1 0 1",
                           done_at, busy_o, done_o, BIST_o); end
    start_i = 1'b0;
    cyc = 1; seen_done = 0;
    for (int n = 0; n < 400 && !seen_done; n++) begin
      @(negedge clk);
      if (done_o) seen_done = 1;
      else if (BIST_o) cyc++;
    end
    checks++; if (seen_done !== 1 || cyc !== 151 || fail_o !== 1'b0) begin
      failures++; $display("FAIL b2b_second_run: done=%0d bist=%0d fail=%b required 1 151 0", seen_done, cyc, fail_o); end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    build_march();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    test_reset();
    test_clean_run();
    test_stuck_bit0();
    test_random_faults();
    test_start_ignored();
    test_reset_midrun();
    test_restart_after_fail();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
